id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of operand and immediate buses.
REQ-002 Parameter CNT_W, default 16, width of bubble counter.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 Mem_Stall_i  input  1  downstream memory stall; freeze whole stage.
REQ-006 Flush_i  input  1  taken branch/jump; kill instruction entering EX.
REQ-007 ID_Valid_i  input  1  ID holds a real instruction.
REQ-008 ID_RS1_i, ID_RS2_i, ID_Rd_i  input  5 each  source/destination register numbers from ID.
REQ-009 ID_Use_RS1_i, ID_Use_RS2_i  input  1 each  instruction actually reads RS1/RS2.
REQ-010 ID_Ctrl_i  input  8  packed control {Branch, ALUOp[1:0], ALUSrc, MemWrite, MemRead, MemtoReg, RegWrite}, bit 0 = RegWrite.
REQ-011 ID_RS1_Data_i, ID_RS2_Data_i, ID_Imm_i  input  DATA_W each  operands and immediate.
REQ-012 ID_Funct_i  input  10  {funct7, funct3}.
REQ-013 ID_EX_Valid_o, ID_EX_RS1_o, ID_EX_RS2_o, ID_EX_Rd_o, ID_EX_Ctrl_o, ID_EX_RS1_Data_o, ID_EX_RS2_Data_o, ID_EX_Imm_o, ID_EX_Funct_o  output  widths as matching inputs  registered ID/EX contents; RS1/RS2 drive forwarding unit.
REQ-014 PC_Write_o, IF_ID_Write_o  output  1 each  combinational enables to PC and IF/ID register.
REQ-015 Bubble_Count_o  output  CNT_W  registered count of inserted bubbles.

Function
REQ-016 Hazard (combinational) SHALL = ID_EX_Valid_o & Ctrl.MemRead & (ID_EX_Rd_o != 0) & ID_Valid_i & ((ID_Use_RS1_i & ID_RS1_i == ID_EX_Rd_o) | (ID_Use_RS2_i & ID_RS2_i == ID_EX_Rd_o)).
REQ-017 PC_Write_o and IF_ID_Write_o SHALL both equal !(Hazard | Mem_Stall_i); Flush_i alone SHALL NOT deassert them.
REQ-018 Per rising edge, priority SHALL be: rst_i > Mem_Stall_i (hold all registers) > Flush_i (bubble) > Hazard (bubble) > load.
REQ-019 Bubble SHALL set Valid=0 and Ctrl, Rd, RS1, RS2, data, imm, funct all to 0.
REQ-020 Load SHALL capture every ID input, latency exactly one cycle; if ID_Valid_i=0 Ctrl SHALL be stored as 0 and Valid as 0.
REQ-021 Bubble_Count_o SHALL increment by 1 on each edge a bubble is loaded (Flush_i or Hazard, not during Mem_Stall_i), saturating at all-ones.
REQ-022 Flush_i and Hazard in same cycle SHALL produce one bubble and one count increment.
REQ-023 Mem_Stall_i with Hazard SHALL hold state, not count, and keep enables low.
REQ-024 Load with ID_EX_Rd_o = 0 SHALL never raise Hazard.
REQ-025 Hazard SHALL clear after exactly one bubble, since stage then holds Valid=0.

Reset
REQ-026 On rst_i=1 at a rising edge all registered outputs SHALL become 0 (equivalent to bubble) and Bubble_Count_o SHALL become 0, overriding Mem_Stall_i and Flush_i, including mid-stall.
REQ-027 After reset PC_Write_o=IF_ID_Write_o=1 while Mem_Stall_i=0.

Structure
REQ-028 Control-vector bit positions, width 8, and funct width SHALL live in the shared pipeline package, reused by EX/MEM and MEM/WB registers.
REQ-029 Hazard detection SHALL be a sub-module hazard_detect (combinational); the register bank and counter reside in id_ex_stage.

Verification
REQ-030 Load x5 (MemRead, Rd=5) then ID add using RS1=5 -> Hazard, enables 0 one cycle, next ID_EX_Ctrl_o=0, Bubble_Count_o=1, add enters EX on following edge.
REQ-031 Same as REQ-030 but ID_Use_RS1_i=0, or Rd=0 -> no hazard, no bubble, count 0.
REQ-032 Flush_i=1 with valid ID instr Rd=7 -> ID_EX_Valid_o=0, ID_EX_Rd_o=0, count +1, enables stay 1.
REQ-033 Mem_Stall_i=1 for 3 cycles with load-use pending -> outputs frozen, enables 0, count unchanged; on release one bubble, count +1.
REQ-034 Force count to all-ones via 2^CNT_W flushes (CNT_W=4 build) -> count stays 15.
REQ-035 rst_i=1 during Mem_Stall_i with Valid=1 -> next edge all outputs 0, count 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-vector layout and funct width.
// Reused by the ID/EX, EX/MEM and MEM/WB pipeline registers.
package id_ex_stage_pkg;

  localparam int CTRL_W  = 8;
  localparam int FUNCT_W = 10;
  localparam int REG_W   = 5;

  // Bit positions inside the packed control vector (bit 0 = RegWrite)
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP_LO  = 5;
  localparam int CTRL_ALU_OP_HI  = 6;
  localparam int CTRL_BRANCH     = 7;

  // Structured view of the same vector, MSB first
  typedef struct packed {
    logic       branch;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  typedef logic [FUNCT_W-1:0] funct_t;

  // Conversion helper for downstream stages that prefer named fields
  function automatic ctrl_t ctrl_unpack(input logic [CTRL_W-1:0] raw);
    return ctrl_t'(raw);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX stage bundle: decoded instruction in, registered contents,
// stall/flush controls and fetch enables out.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                Mem_Stall_i;
  logic                Flush_i;
  logic                ID_Valid_i;
  logic [REG_W-1:0]    ID_RS1_i;
  logic [REG_W-1:0]    ID_RS2_i;
  logic [REG_W-1:0]    ID_Rd_i;
  logic                ID_Use_RS1_i;
  logic                ID_Use_RS2_i;
  logic [CTRL_W-1:0]   ID_Ctrl_i;
  logic [DATA_W-1:0]   ID_RS1_Data_i;
  logic [DATA_W-1:0]   ID_RS2_Data_i;
  logic [DATA_W-1:0]   ID_Imm_i;
  logic [FUNCT_W-1:0]  ID_Funct_i;

  logic                ID_EX_Valid_o;
  logic [REG_W-1:0]    ID_EX_RS1_o;
  logic [REG_W-1:0]    ID_EX_RS2_o;
  logic [REG_W-1:0]    ID_EX_Rd_o;
  logic [CTRL_W-1:0]   ID_EX_Ctrl_o;
  logic [DATA_W-1:0]   ID_EX_RS1_Data_o;
  logic [DATA_W-1:0]   ID_EX_RS2_Data_o;
  logic [DATA_W-1:0]   ID_EX_Imm_o;
  logic [FUNCT_W-1:0]  ID_EX_Funct_o;
  logic                PC_Write_o;
  logic                IF_ID_Write_o;
  logic [CNT_W-1:0]    Bubble_Count_o;

  // Upstream side: drives the decoded instruction and controls
  modport master (
    output Mem_Stall_i, Flush_i, ID_Valid_i, ID_RS1_i, ID_RS2_i, ID_Rd_i,
           ID_Use_RS1_i, ID_Use_RS2_i, ID_Ctrl_i, ID_RS1_Data_i,
           ID_RS2_Data_i, ID_Imm_i, ID_Funct_i,
    input  ID_EX_Valid_o, ID_EX_RS1_o, ID_EX_RS2_o, ID_EX_Rd_o, ID_EX_Ctrl_o,
           ID_EX_RS1_Data_o, ID_EX_RS2_Data_o, ID_EX_Imm_o, ID_EX_Funct_o,
           PC_Write_o, IF_ID_Write_o, Bubble_Count_o
  );

  // Stage side
  modport slave (
    input  Mem_Stall_i, Flush_i, ID_Valid_i, ID_RS1_i, ID_RS2_i, ID_Rd_i,
           ID_Use_RS1_i, ID_Use_RS2_i, ID_Ctrl_i, ID_RS1_Data_i,
           ID_RS2_Data_i, ID_Imm_i, ID_Funct_i,
    output ID_EX_Valid_o, ID_EX_RS1_o, ID_EX_RS2_o, ID_EX_Rd_o, ID_EX_Ctrl_o,
           ID_EX_RS1_Data_o, ID_EX_RS2_Data_o, ID_EX_Imm_o, ID_EX_Funct_o,
           PC_Write_o, IF_ID_Write_o, Bubble_Count_o
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: the load sitting in EX produces its value too
// late for the instruction in ID, which must wait one cycle.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             hazard
);
  logic rs1_hit, rs2_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    rs1_hit = use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = use_rs2 && (id_rs2 == ex_rd);
    hazard  = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
              (rs1_hit || rs2_hit);
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory
// stall freeze and a saturating count of inserted bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
)(
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_stage_if.slave bus
);
  logic               valid_q;
  logic [REG_W-1:0]   rs1_q, rs2_q, rd_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [DATA_W-1:0]  rs1_data_q, rs2_data_q, imm_q;
  logic [FUNCT_W-1:0] funct_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               hazard;
  logic               bubble;

  hazard_detect u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
    .ex_rd       (rd_q),
    .id_valid    (bus.ID_Valid_i),
    .id_rs1      (bus.ID_RS1_i),
    .id_rs2      (bus.ID_RS2_i),
    .use_rs1     (bus.ID_Use_RS1_i),
    .use_rs2     (bus.ID_Use_RS2_i),
    .hazard      (hazard)
  );

  // Fetch enables stall on hazard or memory stall; a flush lets fetch run
  // so the redirected stream can enter immediately.
  always_comb begin
    bus.PC_Write_o    = !(hazard || bus.Mem_Stall_i);
    bus.IF_ID_Write_o = !(hazard || bus.Mem_Stall_i);
    bubble            = bus.Flush_i || hazard;
  end

  // Register bank: reset > stall hold > bubble (flush/hazard) > load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
    end else if (!bus.Mem_Stall_i) begin
      if (bubble) begin
        valid_q    <= 1'b0;
        rs1_q      <= '0;
        rs2_q      <= '0;
        rd_q       <= '0;
        ctrl_q     <= '0;
        rs1_data_q <= '0;
        rs2_data_q <= '0;
        imm_q      <= '0;
        funct_q    <= '0;
      end else begin
        // An empty ID slot still passes its fields, but with no side effects
        valid_q    <= bus.ID_Valid_i;
        ctrl_q     <= bus.ID_Valid_i ? bus.ID_Ctrl_i : '0;
        rs1_q      <= bus.ID_RS1_i;
        rs2_q      <= bus.ID_RS2_i;
        rd_q       <= bus.ID_Rd_i;
        rs1_data_q <= bus.ID_RS1_Data_i;
        rs2_data_q <= bus.ID_RS2_Data_i;
        imm_q      <= bus.ID_Imm_i;
        funct_q    <= bus.ID_Funct_i;
      end
    end
  end

  // Bubble counter: one increment per inserted bubble, sticks at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!bus.Mem_Stall_i && bubble && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered contents out
  always_comb begin
    bus.ID_EX_Valid_o    = valid_q;
    bus.ID_EX_RS1_o      = rs1_q;
    bus.ID_EX_RS2_o      = rs2_q;
    bus.ID_EX_Rd_o       = rd_q;
    bus.ID_EX_Ctrl_o     = ctrl_q;
    bus.ID_EX_RS1_Data_o = rs1_data_q;
    bus.ID_EX_RS2_Data_o = rs2_data_q;
    bus.ID_EX_Imm_o      = imm_q;
    bus.ID_EX_Funct_o    = funct_q;
    bus.Bubble_Count_o   = cnt_q;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage, built with a 4-bit bubble counter so that
// saturation is reachable.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [7:0] LD_CTRL  = 8'h07; // MemRead|MemtoReg|RegWrite
  localparam logic [7:0] ADD_CTRL = 8'h41; // ALUOp=10, RegWrite

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2,
                           input logic [7:0] ctrl, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] imm,
                           input logic [9:0] funct);
    bus.ID_Valid_i    = v;
    bus.ID_RS1_i      = rs1;
    bus.ID_RS2_i      = rs2;
    bus.ID_Rd_i       = rd;
    bus.ID_Use_RS1_i  = u1;
    bus.ID_Use_RS2_i  = u2;
    bus.ID_Ctrl_i     = ctrl;
    bus.ID_RS1_Data_i = d1;
    bus.ID_RS2_Data_i = d2;
    bus.ID_Imm_i      = imm;
    bus.ID_Funct_i    = funct;
  endtask

  task automatic idle();
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 10'h0);
    bus.Mem_Stall_i = 1'b0;
    bus.Flush_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // load x5 <- mem, then present "add x8, x5, x6" in ID
  task automatic load_x5(input logic [4:0] rd);
    set_instr(1'b1, 5'd2, 5'd0, rd, 1'b1, 1'b0, LD_CTRL, 32'h100, 32'h0, 32'h10, 10'h002);
    tick();
  endtask

  task automatic present_add(input logic u1, input logic [4:0] rs1);
    set_instr(1'b1, rs1, 5'd6, 5'd8, u1, 1'b1, ADD_CTRL, 32'hAAAA_0001, 32'h5555_0002,
              32'h0, 10'h000);
    #1;
  endtask

  task automatic test_reset();
    set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'hFF, 32'h1, 32'h2, 32'h3, 10'h3FF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (bus.ID_EX_Valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", bus.ID_EX_Valid_o); end
    checks++; if (bus.ID_EX_Ctrl_o !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%0h exp=0", bus.ID_EX_Ctrl_o); end
    checks++; if (bus.ID_EX_Rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0h exp=0", bus.ID_EX_Rd_o); end
    checks++; if (bus.Bubble_Count_o !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.Bubble_Count_o); end
    checks++; if ({bus.PC_Write_o, bus.IF_ID_Write_o} !== 2'b11) begin errors++; $display("FAIL reset_enables got=%b exp=11", {bus.PC_Write_o, bus.IF_ID_Write_o}); end
  endtask

  task automatic test_load();
    do_reset();
    set_instr(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 8'h11, 32'hDEAD_BEEF, 32'h1234_5678,
              32'hFFFF_FFF0, 10'h2A5);
    tick();
    checks++; if (bus.ID_EX_Valid_o !== 1'b1) begin errors++; $display("FAIL load_valid got=%0h exp=1", bus.ID_EX_Valid_o); end
    checks++; if ({bus.ID_EX_RS1_o, bus.ID_EX_RS2_o, bus.ID_EX_Rd_o} !== {5'd3, 5'd4, 5'd9}) begin errors++; $display("FAIL load_regs got=%0h exp=%0h", {bus.ID_EX_RS1_o, bus.ID_EX_RS2_o, bus.ID_EX_Rd_o}, {5'd3, 5'd4, 5'd9}); end
    checks++; if (bus.ID_EX_Ctrl_o !== 8'h11) begin errors++; $display("FAIL load_ctrl got=%0h exp=11", bus.ID_EX_Ctrl_o); end
    checks++; if ({bus.ID_EX_RS1_Data_o, bus.ID_EX_RS2_Data_o, bus.ID_EX_Imm_o} !== {32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFF0}) begin errors++; $display("FAIL load_data got=%0h", {bus.ID_EX_RS1_Data_o, bus.ID_EX_RS2_Data_o, bus.ID_EX_Imm_o}); end
    checks++; if (bus.ID_EX_Funct_o !== 10'h2A5) begin errors++; $display("FAIL load_funct got=%0h exp=2a5", bus.ID_EX_Funct_o); end
    // empty ID slot: control must be dropped, valid low
    set_instr(1'b0, 5'd1, 5'd1, 5'd12, 1'b0, 1'b0, 8'hFF, 32'h7, 32'h8, 32'h9, 10'h1);
    tick();
    checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Ctrl_o} !== 9'h000) begin errors++; $display("FAIL load_invalid got=%0h exp=0", {bus.ID_EX_Valid_o, bus.ID_EX_Ctrl_o}); end
    checks++; if (bus.Bubble_Count_o !== 4'd0) begin errors++; $display("FAIL load_count got=%0d exp=0", bus.Bubble_Count_o); end
  endtask

  task automatic test_load_use();
    do_reset();
    load_x5(5'd5);
    present_add(1'b1, 5'd5);
    checks++; if ({bus.PC_Write_o, bus.IF_ID_Write_o} !== 2'b00) begin errors++; $display("FAIL lu_enables got=%b exp=00", {bus.PC_Write_o, bus.IF_ID_Write_o}); end
    tick();
    checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Ctrl_o, bus.ID_EX_Rd_o} !== 14'h0) begin errors++; $display("FAIL lu_bubble got=%0h exp=0", {bus.ID_EX_Valid_o, bus.ID_EX_Ctrl_o, bus.ID_EX_Rd_o}); end
    checks++; if (bus.Bubble_Count_o !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", bus.Bubble_Count_o); end
    checks++; if ({bus.PC_Write_o, bus.IF_ID_Write_o} !== 2'b11) begin errors++; $display("FAIL lu_release got=%b exp=11", {bus.PC_Write_o, bus.IF_ID_Write_o}); end
    tick();
    checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_RS1_o, bus.ID_EX_Ctrl_o} !== {1'b1, 5'd8, 5'd5, ADD_CTRL}) begin errors++; $display("FAIL lu_add_enters got=%0h exp=%0h", {bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_RS1_o, bus.ID_EX_Ctrl_o}, {1'b1, 5'd8, 5'd5, ADD_CTRL}); end
    checks++; if (bus.Bubble_Count_o !== 4'd1) begin errors++; $display("FAIL lu_count_hold got=%0d exp=1", bus.Bubble_Count_o); end
  endtask

  task automatic test_no_hazard();
    // RS1 matches but is not read (RS2=6 does not match)
    do_reset();
    load_x5(5'd5);
    present_add(1'b0, 5'd5);
    checks++; if ({bus.PC_Write_o, bus.IF_ID_Write_o} !== 2'b11) begin errors++; $display("FAIL nouse_enables got=%b exp=11", {bus.PC_Write_o, bus.IF_ID_Write_o}); end
    tick();
    checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.Bubble_Count_o} !== {1'b1, 5'd8, 4'd0}) begin errors++; $display("FAIL nouse_load got=%0h exp=%0h", {bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.Bubble_Count_o}, {1'b1, 5'd8, 4'd0}); end
    // load to x0 followed by a reader of x0
    do_reset();
    load_x5(5'd0);
    present_add(1'b1, 5'd0);
    checks++; if ({bus.PC_Write_o, bus.IF_ID_Write_o} !== 2'b11) begin errors++; $display("FAIL x0_enables got=%b exp=11", {bus.PC_Write_o, bus.IF_ID_Write_o}); end
    tick();
    checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.Bubble_Count_o} !== {1'b1, 5'd8, 4'd0}) begin errors++; $display("FAIL x0_load got=%0h exp=%0h", {bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.Bubble_Count_o}, {1'b1, 5'd8, 4'd0}); end
  endtask

  task automatic test_flush();
    do_reset();
    set_instr(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, ADD_CTRL, 32'h11, 32'h22, 32'h33, 10'h5);
    bus.Flush_i = 1'b1;
    #1;
    checks++; if ({bus.PC_Write_o, bus.IF_ID_Write_o} !== 2'b11) begin errors++; $display("FAIL flush_enables got=%b exp=11", {bus.PC_Write_o, bus.IF_ID_Write_o}); end
    tick();
    bus.Flush_i = 1'b0;
    checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_RS1_Data_o} !== 38'h0) begin errors++; $display("FAIL flush_bubble got=%0h exp=0", {bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_RS1_Data_o}); end
    checks++; if (bus.Bubble_Count_o !== 4'd1) begin errors++; $display("FAIL flush_count got=%0d exp=1", bus.Bubble_Count_o); end
    // flush together with a hazard: one bubble, one increment
    load_x5(5'd5);
    present_add(1'b1, 5'd5);
    bus.Flush_i = 1'b1;
    tick();
    bus.Flush_i = 1'b0;
    checks++; if ({bus.ID_EX_Valid_o, bus.Bubble_Count_o} !== {1'b0, 4'd2}) begin errors++; $display("FAIL flush_hazard got=%0h exp=%0h", {bus.ID_EX_Valid_o, bus.Bubble_Count_o}, {1'b0, 4'd2}); end
  endtask

  task automatic test_stall();
    do_reset();
    load_x5(5'd5);
    present_add(1'b1, 5'd5);
    bus.Mem_Stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({bus.PC_Write_o, bus.IF_ID_Write_o} !== 2'b00) begin errors++; $display("FAIL stall_enables_%0d got=%b exp=00", i, {bus.PC_Write_o, bus.IF_ID_Write_o}); end
      tick();
      checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_Ctrl_o, bus.Bubble_Count_o} !== {1'b1, 5'd5, LD_CTRL, 4'd0}) begin errors++; $display("FAIL stall_hold_%0d got=%0h exp=%0h", i, {bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_Ctrl_o, bus.Bubble_Count_o}, {1'b1, 5'd5, LD_CTRL, 4'd0}); end
    end
    bus.Mem_Stall_i = 1'b0;
    tick();
    checks++; if ({bus.ID_EX_Valid_o, bus.Bubble_Count_o} !== {1'b0, 4'd1}) begin errors++; $display("FAIL stall_release got=%0h exp=%0h", {bus.ID_EX_Valid_o, bus.Bubble_Count_o}, {1'b0, 4'd1}); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.Flush_i = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (bus.Bubble_Count_o !== 4'd15) begin errors++; $display("FAIL sat_16 got=%0d exp=15", bus.Bubble_Count_o); end
    tick();
    tick();
    bus.Flush_i = 1'b0;
    checks++; if (bus.Bubble_Count_o !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", bus.Bubble_Count_o); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.Flush_i = 1'b1;
    tick();
    bus.Flush_i = 1'b0;
    set_instr(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, ADD_CTRL, 32'h99, 32'h88, 32'h77, 10'h3);
    tick();
    bus.Mem_Stall_i = 1'b1;
    bus.Flush_i     = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_Ctrl_o, bus.ID_EX_RS1_Data_o, bus.ID_EX_Funct_o} !== 56'h0) begin errors++; $display("FAIL rst_stall_regs got=%0h exp=0", {bus.ID_EX_Valid_o, bus.ID_EX_Rd_o, bus.ID_EX_Ctrl_o, bus.ID_EX_RS1_Data_o, bus.ID_EX_Funct_o}); end
    checks++; if (bus.Bubble_Count_o !== 4'd0) begin errors++; $display("FAIL rst_stall_count got=%0d exp=0", bus.Bubble_Count_o); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_stall();
    test_saturate();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
